mannix_ddr_bridge: RTL and testbench
====================================

Name: mannix_ddr_bridge

Overview:
- Downstream of the accelerator top's memory farm.
- Consumes its DDR line read and line write requests (16 words x 256 bit, 32-bit byte address) and runs each as a single burst on an external DDR port using valid/ready channels.
- One transaction in flight at a time. Read and write requests are arbitrated.

Parameters:
ADDR_WIDTH, 32, DDR byte address width
WORD_WIDTH, 256, data bits per beat/word
NUM_WORDS_IN_LINE, 16, beats per line burst
LOG2_WORDS, $clog2(NUM_WORDS_IN_LINE), beat counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rd_req_valid  in  1  line read request
rd_req_addr  in  ADDR_WIDTH  line read byte address
rd_req_ready  out  1  read request accepted
rd_word_valid  out  1  returned read word valid
rd_word_data  out  WORD_WIDTH  returned read word
rd_word_idx  out  LOG2_WORDS  word index within line
rd_line_done  out  1  pulse with last read word
wr_req_valid  in  1  line write request
wr_req_addr  in  ADDR_WIDTH  line write byte address
wr_req_ready  out  1  write request accepted
wr_word_ready  out  1  bridge takes wr_word_data this cycle
wr_word_data  in  WORD_WIDTH  write word (client holds word i until taken)
wr_line_done  out  1  pulse on write response
wr_priority  in  1  1 = write wins a tie; 0 = read wins
ddr_ar_valid/ddr_ar_ready  out/in  1  read address handshake
ddr_ar_addr  out  ADDR_WIDTH  burst start address
ddr_r_valid/ddr_r_ready  in/out  1  read data handshake
ddr_r_data  in  WORD_WIDTH  read beat
ddr_r_last  in  1  last read beat
ddr_aw_valid/ddr_aw_ready  out/in  1  write address handshake
ddr_aw_addr  out  ADDR_WIDTH  burst start address
ddr_w_valid/ddr_w_ready  out/in  1  write data handshake
ddr_w_data  out  WORD_WIDTH  write beat
ddr_w_last  out  1  last write beat
ddr_b_valid/ddr_b_ready  in/out  1  write response handshake
busy  out  1  FSM not IDLE

Behaviour:
- Reset (async, rst=1): FSM to IDLE, beat counter 0. All outputs 0, including data and address buses.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- IDLE:
  - rd_req_ready = wr_req_ready = 0 until the request is granted.
  - Grant happens in the cycle of request. The accepted side's *_req_ready is a 1-cycle pulse, registered from the grant.
  - Tie resolved by wr_priority. A sole request is always granted.
  - Address is latched at grant.
- Request-to-channel latency: ddr_ar_valid (or ddr_aw_valid) is asserted the cycle after grant.
- RD_ADDR: hold ddr_ar_valid with latched address until ddr_ar_ready, then go to RD_DATA.
- RD_DATA:
  - ddr_r_ready = 1 always (client cannot stall).
  - Each r handshake, registered one cycle later: rd_word_valid=1, rd_word_data, rd_word_idx=counter; counter increments.
  - When counter reaches NUM_WORDS_IN_LINE-1: assert rd_line_done with that word and return to IDLE.
  - ddr_r_last early or late versus the counter: counter governs; mismatch sets the sticky bit protocol_err (internal, visible in busy only via hang-free return).
- WR_ADDR: ddr_aw_valid until ddr_aw_ready, then go to WR_DATA. Write data is not sent before the address is accepted.
- WR_DATA:
  - ddr_w_valid = 1 with ddr_w_data = wr_word_data and wr_word_ready = ddr_w_ready (combinational pass-through).
  - ddr_w_last = 1 when counter = NUM_WORDS_IN_LINE-1.
  - After the last handshake go to WR_RESP.
- WR_RESP: ddr_b_ready = 1. On ddr_b_valid, pulse wr_line_done for 1 cycle and return to IDLE.
- Counter: LOG2_WORDS bits, wraps to 0 at line end, cleared on every grant.
- Requests arriving while busy are not acknowledged; the client holds them. No starvation guarantee beyond wr_priority.
- Reset mid-burst: abandon immediately and drive all outputs 0. The DDR side is also reset by the same rst.
- busy = (state != IDLE).

Optional Feature:
- Macro MANNIX_DDR_TIMEOUT_EN adds parameter TIMEOUT_CYCLES (default 1024) and output timeout_err (1 bit, sticky until rst).
- With the macro: a cycle counter runs in any non-IDLE state and resets on every DDR handshake. On reaching TIMEOUT_CYCLES:
  - set timeout_err;
  - pulse the relevant *_line_done;
  - force IDLE.
  - Read words not yet delivered are dropped.
- Without the macro: no port or counter exists, and the FSM waits indefinitely.

Test Plan:
- Single read at 0x0000_1000, ar_ready after 3 cycles, 16 back-to-back r beats of data i -> ar_addr=0x1000; rd_word_idx 0..15 with matching data; rd_line_done coincident with idx 15; busy low the next cycle.
- Single write at 0x0000_2000, w_ready toggling 1/0 -> exactly 16 w beats, w_last only on beat 16, data order preserved; wr_line_done 1 cycle after b_valid.
- rd_req and wr_req asserted in the same cycle, wr_priority=1 -> write served first, read granted in the cycle after return to IDLE; repeat with wr_priority=0 -> read first.
- rst asserted during beat 7 of a read -> all outputs 0 asynchronously; after release, a new read completes normally from idx 0.
- Back-to-back reads at 0x0 and 0x200 -> two bursts, counter restarts at 0, no overlap of ar_valid with the first burst's r data.
- (MANNIX_DDR_TIMEOUT_EN, TIMEOUT_CYCLES=16) ar_ready never asserted -> timeout_err=1 at cycle 16 after grant, rd_line_done pulse, FSM IDLE.

Source files
------------

// File: rtl/mannix_ddr_bridge.sv
// mannix_ddr_bridge: turns line read/write requests (NUM_WORDS_IN_LINE words)
// into single DDR bursts over valid/ready channels, one transaction at a time.
// Optional build macro MANNIX_DDR_TIMEOUT_EN adds parameter TIMEOUT_CYCLES and
// the sticky output timeout_err; without it the FSM waits on the DDR side forever.
module mannix_ddr_bridge #(
   parameter int ADDR_WIDTH        = 32,
   parameter int WORD_WIDTH        = 256,
   parameter int NUM_WORDS_IN_LINE = 16,
   parameter int LOG2_WORDS        = $clog2(NUM_WORDS_IN_LINE)
`ifdef MANNIX_DDR_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES   = 1024
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_req_valid,
   input  logic [ADDR_WIDTH-1:0] rd_req_addr,
   output logic                  rd_req_ready,
   output logic                  rd_word_valid,
   output logic [WORD_WIDTH-1:0] rd_word_data,
   output logic [LOG2_WORDS-1:0] rd_word_idx,
   output logic                  rd_line_done,
   input  logic                  wr_req_valid,
   input  logic [ADDR_WIDTH-1:0] wr_req_addr,
   output logic                  wr_req_ready,
   output logic                  wr_word_ready,
   input  logic [WORD_WIDTH-1:0] wr_word_data,
   output logic                  wr_line_done,
   input  logic                  wr_priority,
   output logic                  ddr_ar_valid,
   input  logic                  ddr_ar_ready,
   output logic [ADDR_WIDTH-1:0] ddr_ar_addr,
   input  logic                  ddr_r_valid,
   output logic                  ddr_r_ready,
   input  logic [WORD_WIDTH-1:0] ddr_r_data,
   input  logic                  ddr_r_last,
   output logic                  ddr_aw_valid,
   input  logic                  ddr_aw_ready,
   output logic [ADDR_WIDTH-1:0] ddr_aw_addr,
   output logic                  ddr_w_valid,
   input  logic                  ddr_w_ready,
   output logic [WORD_WIDTH-1:0] ddr_w_data,
   output logic                  ddr_w_last,
   input  logic                  ddr_b_valid,
   output logic                  ddr_b_ready,
`ifdef MANNIX_DDR_TIMEOUT_EN
   output logic                  timeout_err,
`endif
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP
   } state_t;

   state_t                state_q, state_d;
   logic [LOG2_WORDS-1:0] cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  rd_req_ready_q, rd_req_ready_d;
   logic                  wr_req_ready_q, wr_req_ready_d;
   logic                  rd_word_valid_q, rd_word_valid_d;
   logic [WORD_WIDTH-1:0] rd_word_data_q, rd_word_data_d;
   logic [LOG2_WORDS-1:0] rd_word_idx_q, rd_word_idx_d;
   logic                  rd_line_done_q, rd_line_done_d;
   logic                  wr_line_done_q, wr_line_done_d;
   // Sticky flag: ddr_r_last disagreed with the beat counter (counter still rules).
   logic                  protocol_err_q, protocol_err_d;
   logic                  grant_wr, grant_rd, last_beat;

`ifdef MANNIX_DDR_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            timeout_err_q, timeout_err_d;
   logic            hs_any;
   assign timeout_err = timeout_err_q;
   assign hs_any = (state_q == S_RD_ADDR && ddr_ar_ready) ||
                   (state_q == S_RD_DATA && ddr_r_valid)  ||
                   (state_q == S_WR_ADDR && ddr_aw_ready) ||
                   (state_q == S_WR_DATA && ddr_w_ready)  ||
                   (state_q == S_WR_RESP && ddr_b_valid);
`endif

   // Write wins when it is the only request or when wr_priority breaks a tie.
   assign grant_wr  = wr_req_valid & (wr_priority | ~rd_req_valid);
   assign grant_rd  = rd_req_valid & ~grant_wr;
   assign last_beat = (cnt_q == LOG2_WORDS'(NUM_WORDS_IN_LINE - 1));

   // State register and all registered outputs; reset abandons any burst at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         addr_q          <= '0;
         rd_req_ready_q  <= 1'b0;
         wr_req_ready_q  <= 1'b0;
         rd_word_valid_q <= 1'b0;
         rd_word_data_q  <= '0;
         rd_word_idx_q   <= '0;
         rd_line_done_q  <= 1'b0;
         wr_line_done_q  <= 1'b0;
         protocol_err_q  <= 1'b0;
`ifdef MANNIX_DDR_TIMEOUT_EN
         to_cnt_q        <= '0;
         timeout_err_q   <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         addr_q          <= addr_d;
         rd_req_ready_q  <= rd_req_ready_d;
         wr_req_ready_q  <= wr_req_ready_d;
         rd_word_valid_q <= rd_word_valid_d;
         rd_word_data_q  <= rd_word_data_d;
         rd_word_idx_q   <= rd_word_idx_d;
         rd_line_done_q  <= rd_line_done_d;
         wr_line_done_q  <= wr_line_done_d;
         protocol_err_q  <= protocol_err_d;
`ifdef MANNIX_DDR_TIMEOUT_EN
         to_cnt_q        <= to_cnt_d;
         timeout_err_q   <= timeout_err_d;
`endif
      end
   end

   // Next-state logic: arbitration, burst sequencing, beat counter, read word capture.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      addr_d          = addr_q;
      rd_req_ready_d  = 1'b0;
      wr_req_ready_d  = 1'b0;
      rd_word_valid_d = 1'b0;
      rd_word_data_d  = rd_word_data_q;
      rd_word_idx_d   = rd_word_idx_q;
      rd_line_done_d  = 1'b0;
      wr_line_done_d  = 1'b0;
      protocol_err_d  = protocol_err_q;
      case (state_q)
         S_IDLE: begin
            if (grant_wr) begin
               state_d        = S_WR_ADDR;
               addr_d         = wr_req_addr;
               cnt_d          = '0;
               wr_req_ready_d = 1'b1;
            end else if (grant_rd) begin
               state_d        = S_RD_ADDR;
               addr_d         = rd_req_addr;
               cnt_d          = '0;
               rd_req_ready_d = 1'b1;
            end
         end
         S_RD_ADDR: if (ddr_ar_ready) state_d = S_RD_DATA;
         S_RD_DATA: begin
            if (ddr_r_valid) begin
               rd_word_valid_d = 1'b1;
               rd_word_data_d  = ddr_r_data;
               rd_word_idx_d   = cnt_q;
               cnt_d           = last_beat ? '0 : cnt_q + 1'b1;
               if (ddr_r_last != last_beat) protocol_err_d = 1'b1;
               if (last_beat) begin
                  rd_line_done_d = 1'b1;
                  state_d        = S_IDLE;
               end
            end
         end
         S_WR_ADDR: if (ddr_aw_ready) state_d = S_WR_DATA;
         S_WR_DATA: begin
            if (ddr_w_ready) begin
               cnt_d = last_beat ? '0 : cnt_q + 1'b1;
               if (last_beat) state_d = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            if (ddr_b_valid) begin
               wr_line_done_d = 1'b1;
               state_d        = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef MANNIX_DDR_TIMEOUT_EN
      // Watchdog: any handshake restarts it; expiry closes the line and forces IDLE.
      to_cnt_d      = to_cnt_q;
      timeout_err_d = timeout_err_q;
      if (state_q == S_IDLE || hs_any) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
         to_cnt_d      = '0;
         timeout_err_d = 1'b1;
         state_d       = S_IDLE;
         if (state_q == S_RD_ADDR || state_q == S_RD_DATA) rd_line_done_d = 1'b1;
         else                                               wr_line_done_d = 1'b1;
      end else begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
`endif
   end

   // Channel outputs decoded from state; everything is 0 in IDLE and therefore in reset.
   always_comb begin
      ddr_ar_valid  = 1'b0;
      ddr_ar_addr   = '0;
      ddr_r_ready   = 1'b0;
      ddr_aw_valid  = 1'b0;
      ddr_aw_addr   = '0;
      ddr_w_valid   = 1'b0;
      ddr_w_data    = '0;
      ddr_w_last    = 1'b0;
      wr_word_ready = 1'b0;
      ddr_b_ready   = 1'b0;
      case (state_q)
         S_RD_ADDR: begin
            ddr_ar_valid = 1'b1;
            ddr_ar_addr  = addr_q;
         end
         S_RD_DATA: ddr_r_ready = 1'b1;
         S_WR_ADDR: begin
            ddr_aw_valid = 1'b1;
            ddr_aw_addr  = addr_q;
         end
         S_WR_DATA: begin
            ddr_w_valid   = 1'b1;
            ddr_w_data    = wr_word_data;
            ddr_w_last    = last_beat;
            wr_word_ready = ddr_w_ready;
         end
         S_WR_RESP: ddr_b_ready = 1'b1;
         default: ;
      endcase
   end

   assign rd_req_ready  = rd_req_ready_q;
   assign wr_req_ready  = wr_req_ready_q;
   assign rd_word_valid = rd_word_valid_q;
   assign rd_word_data  = rd_word_data_q;
   assign rd_word_idx   = rd_word_idx_q;
   assign rd_line_done  = rd_line_done_q;
   assign wr_line_done  = wr_line_done_q;
   assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_mannix_ddr_bridge.sv
// Directed bench for mannix_ddr_bridge: a table of single read/write lines plus
// hand-written sequences for arbitration ties, back-to-back reads and mid-burst reset.
module tb_mannix_ddr_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req_valid;
  logic [31:0]  rd_req_addr;
  logic         rd_req_ready;
  logic         rd_word_valid;
  logic [255:0] rd_word_data;
  logic [3:0]   rd_word_idx;
  logic         rd_line_done;
  logic         wr_req_valid;
  logic [31:0]  wr_req_addr;
  logic         wr_req_ready;
  logic         wr_word_ready;
  logic [255:0] wr_word_data;
  logic         wr_line_done;
  logic         wr_priority;
  logic         ddr_ar_valid, ddr_ar_ready;
  logic [31:0]  ddr_ar_addr;
  logic         ddr_r_valid, ddr_r_ready, ddr_r_last;
  logic [255:0] ddr_r_data;
  logic         ddr_aw_valid, ddr_aw_ready;
  logic [31:0]  ddr_aw_addr;
  logic         ddr_w_valid, ddr_w_ready, ddr_w_last;
  logic [255:0] ddr_w_data;
  logic         ddr_b_valid, ddr_b_ready;
  logic         busy;
`ifdef MANNIX_DDR_TIMEOUT_EN
  logic         timeout_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef MANNIX_DDR_TIMEOUT_EN
  mannix_ddr_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_word_valid(rd_word_valid), .rd_word_data(rd_word_data), .rd_word_idx(rd_word_idx),
    .rd_line_done(rd_line_done),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_ready(wr_req_ready),
    .wr_word_ready(wr_word_ready), .wr_word_data(wr_word_data), .wr_line_done(wr_line_done),
    .wr_priority(wr_priority),
    .ddr_ar_valid(ddr_ar_valid), .ddr_ar_ready(ddr_ar_ready), .ddr_ar_addr(ddr_ar_addr),
    .ddr_r_valid(ddr_r_valid), .ddr_r_ready(ddr_r_ready), .ddr_r_data(ddr_r_data),
    .ddr_r_last(ddr_r_last),
    .ddr_aw_valid(ddr_aw_valid), .ddr_aw_ready(ddr_aw_ready), .ddr_aw_addr(ddr_aw_addr),
    .ddr_w_valid(ddr_w_valid), .ddr_w_ready(ddr_w_ready), .ddr_w_data(ddr_w_data),
    .ddr_w_last(ddr_w_last),
    .ddr_b_valid(ddr_b_valid), .ddr_b_ready(ddr_b_ready),
    .timeout_err(timeout_err),
    .busy(busy)
  );
`else
  mannix_ddr_bridge dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_word_valid(rd_word_valid), .rd_word_data(rd_word_data), .rd_word_idx(rd_word_idx),
    .rd_line_done(rd_line_done),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_ready(wr_req_ready),
    .wr_word_ready(wr_word_ready), .wr_word_data(wr_word_data), .wr_line_done(wr_line_done),
    .wr_priority(wr_priority),
    .ddr_ar_valid(ddr_ar_valid), .ddr_ar_ready(ddr_ar_ready), .ddr_ar_addr(ddr_ar_addr),
    .ddr_r_valid(ddr_r_valid), .ddr_r_ready(ddr_r_ready), .ddr_r_data(ddr_r_data),
    .ddr_r_last(ddr_r_last),
    .ddr_aw_valid(ddr_aw_valid), .ddr_aw_ready(ddr_aw_ready), .ddr_aw_addr(ddr_aw_addr),
    .ddr_w_valid(ddr_w_valid), .ddr_w_ready(ddr_w_ready), .ddr_w_data(ddr_w_data),
    .ddr_w_last(ddr_w_last),
    .ddr_b_valid(ddr_b_valid), .ddr_b_ready(ddr_b_ready),
    .busy(busy)
  );
`endif

  typedef struct {
    bit           is_wr;
    logic [31:0]  addr;
    int           dly;      // cycles before ar/aw_ready
    bit           toggle;   // write: w_ready alternates 1/0
    int           last_at;  // read: beat index carrying ddr_r_last
    logic [255:0] seed;     // beat i carries seed + i
    logic [31:0]  exp_addr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk_w({name, "_ctrl"}, 256'({rd_req_ready, wr_req_ready, rd_word_valid, rd_line_done,
          wr_word_ready, wr_line_done, ddr_ar_valid, ddr_r_ready, ddr_aw_valid,
          ddr_w_valid, ddr_w_last, ddr_b_ready, busy}), 256'(0));
    chk_w({name, "_rdata"}, rd_word_data, 256'(0));
    chk_w({name, "_ridx"}, 256'(rd_word_idx), 256'(0));
    chk_w({name, "_araddr"}, 256'(ddr_ar_addr), 256'(0));
    chk_w({name, "_awaddr"}, 256'(ddr_aw_addr), 256'(0));
    chk_w({name, "_wdata"}, ddr_w_data, 256'(0));
  endtask

  // Entered at the negedge after the read grant (ar_valid already up).
  task automatic finish_read(input int dly, input logic [255:0] seed, input int last_at,
                             input int stop_after, input logic [31:0] exp_addr);
    for (int c = 0; c < dly; c++) begin
      ddr_ar_ready = 1'b0;
      @(negedge clk);
      chk_b("ar_hold_valid", ddr_ar_valid, 1'b1);
      chk_w("ar_hold_addr", 256'(ddr_ar_addr), 256'(exp_addr));
      chk_b("rd_ready_pulse", rd_req_ready, 1'b0);
    end
    ddr_ar_ready = 1'b1;
    @(negedge clk);
    ddr_ar_ready = 1'b0;
    chk_b("ar_drop", ddr_ar_valid, 1'b0);
    chk_b("r_ready", ddr_r_ready, 1'b1);
    for (int i = 0; i < stop_after; i++) begin
      ddr_r_valid = 1'b1;
      ddr_r_data  = seed + 256'(i);
      ddr_r_last  = (i == last_at);
      @(negedge clk);
      chk_b("rd_valid", rd_word_valid, 1'b1);
      chk_w("rd_idx", 256'(rd_word_idx), 256'(i));
      chk_w("rd_data", rd_word_data, seed + 256'(i));
      chk_b("rd_done", rd_line_done, (i == 15));
      chk_b("ar_no_overlap", ddr_ar_valid, 1'b0);
      chk_b("rd_busy_noack", rd_req_ready, 1'b0);
      if (i == 15) chk_b("rd_busy_end", busy, 1'b0);
    end
    ddr_r_valid = 1'b0;
    ddr_r_last  = 1'b0;
  endtask

  // Entered at the negedge after the write grant; ends at the wr_line_done cycle.
  task automatic finish_write(input int dly, input bit toggle, input logic [255:0] seed,
                              input logic [31:0] exp_addr, input int b_dly);
    int beats = 0;
    int cyc   = 0;
    for (int c = 0; c < dly; c++) begin
      ddr_aw_ready = 1'b0;
      @(negedge clk);
      chk_b("aw_hold_valid", ddr_aw_valid, 1'b1);
      chk_w("aw_hold_addr", 256'(ddr_aw_addr), 256'(exp_addr));
      chk_b("w_before_aw", ddr_w_valid, 1'b0);
    end
    ddr_aw_ready = 1'b1;
    @(negedge clk);
    ddr_aw_ready = 1'b0;
    chk_b("aw_drop", ddr_aw_valid, 1'b0);
    while (beats < 16 && cyc < 100) begin
      wr_word_data = seed + 256'(beats);
      ddr_w_ready  = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      chk_b("w_valid", ddr_w_valid, 1'b1);
      chk_w("w_data", ddr_w_data, seed + 256'(beats));
      chk_b("w_last", ddr_w_last, (beats == 15));
      chk_b("wr_word_ready", wr_word_ready, ddr_w_ready);
      if (ddr_w_ready) beats++;
      cyc++;
      @(negedge clk);
    end
    ddr_w_ready = 1'b0;
    chk_w("w_beat_count", 256'(beats), 256'(16));
    chk_b("w_valid_after16", ddr_w_valid, 1'b0);
    chk_b("b_ready", ddr_b_ready, 1'b1);
    for (int c = 0; c < b_dly; c++) begin
      @(negedge clk);
      chk_b("b_wait_done", wr_line_done, 1'b0);
    end
    ddr_b_valid = 1'b1;
    @(negedge clk);
    ddr_b_valid = 1'b0;
    chk_b("wr_done", wr_line_done, 1'b1);
    chk_b("wr_busy_end", busy, 1'b0);
  endtask

  task automatic run_read(input vec_t v);
    rd_req_valid = 1'b1;
    rd_req_addr  = v.addr;
    #1;
    chk_b("rd_ready_pre", rd_req_ready, 1'b0);
    @(negedge clk);
    chk_b("rd_ready", rd_req_ready, 1'b1);
    chk_b("ar_valid", ddr_ar_valid, 1'b1);
    chk_w("ar_addr", 256'(ddr_ar_addr), 256'(v.exp_addr));
    chk_b("rd_busy", busy, 1'b1);
    rd_req_valid = 1'b0;
    finish_read(v.dly, v.seed, v.last_at, 16, v.exp_addr);
    @(negedge clk);
    chk_b("rd_valid_after", rd_word_valid, 1'b0);
    chk_b("rd_done_pulse", rd_line_done, 1'b0);
    chk_b("rd_idle", busy, 1'b0);
  endtask

  task automatic run_write(input vec_t v);
    wr_req_valid = 1'b1;
    wr_req_addr  = v.addr;
    #1;
    chk_b("wr_ready_pre", wr_req_ready, 1'b0);
    @(negedge clk);
    chk_b("wr_ready", wr_req_ready, 1'b1);
    chk_b("aw_valid", ddr_aw_valid, 1'b1);
    chk_w("aw_addr", 256'(ddr_aw_addr), 256'(v.exp_addr));
    wr_req_valid = 1'b0;
    finish_write(v.dly, v.toggle, v.seed, v.exp_addr, 2);
    @(negedge clk);
    chk_b("wr_done_pulse", wr_line_done, 1'b0);
    chk_b("wr_idle", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_1000, 3, 1'b0, 15, 256'hA000, 32'h0000_1000};
    vecs[1] = '{1'b1, 32'h0000_2000, 0, 1'b1, 0,  256'hB000, 32'h0000_2000};
    vecs[2] = '{1'b0, 32'hFFFF_FFC0, 0, 1'b0, 7,  {64'hDEAD, 192'h0}, 32'hFFFF_FFC0};
    vecs[3] = '{1'b1, 32'h0000_0040, 2, 1'b0, 0,  {128'h1234_5678, 128'h9}, 32'h0000_0040};
    vecs[4] = '{1'b0, 32'h0000_0800, 1, 1'b0, 16, 256'hC0, 32'h0000_0800};

    rst = 1'b1;
    rd_req_valid = 1'b0; rd_req_addr = 32'h0;
    wr_req_valid = 1'b0; wr_req_addr = 32'hFFFF_FFFF;
    wr_word_data = '1;   wr_priority = 1'b0;
    ddr_ar_ready = 1'b0; ddr_r_valid = 1'b0; ddr_r_data = '0; ddr_r_last = 1'b0;
    ddr_aw_ready = 1'b0; ddr_w_ready = 1'b1; ddr_b_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    ddr_w_ready = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      if (vecs[k].is_wr) run_write(vecs[k]);
      else               run_read(vecs[k]);
    end

    // Tie, write priority: write first, read granted in the first IDLE cycle.
    wr_priority = 1'b1;
    rd_req_valid = 1'b1; rd_req_addr = 32'h0000_3000;
    wr_req_valid = 1'b1; wr_req_addr = 32'h0000_4000;
    @(negedge clk);
    chk_b("tie1_wr_ready", wr_req_ready, 1'b1);
    chk_b("tie1_rd_ready", rd_req_ready, 1'b0);
    chk_b("tie1_ar_valid", ddr_ar_valid, 1'b0);
    chk_w("tie1_aw_addr", 256'(ddr_aw_addr), 256'(32'h0000_4000));
    wr_req_valid = 1'b0;
    finish_write(0, 1'b0, 256'h77, 32'h0000_4000, 1);
    @(negedge clk);
    chk_b("tie1_rd_grant", rd_req_ready, 1'b1);
    chk_w("tie1_ar_addr", 256'(ddr_ar_addr), 256'(32'h0000_3000));
    rd_req_valid = 1'b0;
    finish_read(0, 256'h300, 15, 16, 32'h0000_3000);
    @(negedge clk);

    // Tie, read priority: read first, then the write.
    wr_priority = 1'b0;
    rd_req_valid = 1'b1; rd_req_addr = 32'h0000_5000;
    wr_req_valid = 1'b1; wr_req_addr = 32'h0000_6000;
    @(negedge clk);
    chk_b("tie0_rd_ready", rd_req_ready, 1'b1);
    chk_b("tie0_wr_ready", wr_req_ready, 1'b0);
    chk_b("tie0_aw_valid", ddr_aw_valid, 1'b0);
    rd_req_valid = 1'b0;
    finish_read(1, 256'h500, 15, 16, 32'h0000_5000);
    @(negedge clk);
    chk_b("tie0_wr_grant", wr_req_ready, 1'b1);
    chk_w("tie0_aw_addr", 256'(ddr_aw_addr), 256'(32'h0000_6000));
    wr_req_valid = 1'b0;
    finish_write(1, 1'b1, 256'h600, 32'h0000_6000, 0);
    @(negedge clk);

    // Back-to-back reads: second request held during the first burst.
    rd_req_valid = 1'b1; rd_req_addr = 32'h0000_0000;
    @(negedge clk);
    chk_b("b2b_rd_ready0", rd_req_ready, 1'b1);
    chk_w("b2b_ar_addr0", 256'(ddr_ar_addr), 256'(0));
    rd_req_addr = 32'h0000_0200;
    finish_read(1, 256'h1_0000, 15, 16, 32'h0000_0000);
    @(negedge clk);
    chk_b("b2b_rd_ready1", rd_req_ready, 1'b1);
    chk_b("b2b_ar_valid1", ddr_ar_valid, 1'b1);
    chk_w("b2b_ar_addr1", 256'(ddr_ar_addr), 256'(32'h0000_0200));
    rd_req_valid = 1'b0;
    finish_read(0, 256'h2_0000, 15, 16, 32'h0000_0200);
    @(negedge clk);

    // Reset during beat 7 of a read, then a clean read from idx 0.
    rd_req_valid = 1'b1; rd_req_addr = 32'h0000_7000;
    @(negedge clk);
    chk_b("mrst_rd_ready", rd_req_ready, 1'b1);
    rd_req_valid = 1'b0;
    finish_read(0, 256'h7000, 15, 7, 32'h0000_7000);
    ddr_r_valid = 1'b1;
    ddr_r_data  = 256'h7007;
    #2;
    rst = 1'b1;
    #1;
    chk_quiet("midrst");
    @(negedge clk);
    ddr_r_valid = 1'b0;
    ddr_r_data  = '0;
    rst = 1'b0;
    @(negedge clk);
    run_read('{1'b0, 32'h0000_7000, 2, 1'b0, 15, 256'h8000, 32'h0000_7000});

`ifdef MANNIX_DDR_TIMEOUT_EN
    begin
      int n = 0;
      chk_b("to_clear", timeout_err, 1'b0);
      rd_req_valid = 1'b1; rd_req_addr = 32'h0000_9000;
      @(negedge clk);
      rd_req_valid = 1'b0;
      while (!timeout_err && n < 64) begin
        @(negedge clk);
        n++;
      end
      chk_w("to_cycles", 256'(n), 256'(16));
      chk_b("to_err", timeout_err, 1'b1);
      chk_b("to_rd_done", rd_line_done, 1'b1);
      chk_b("to_idle", busy, 1'b0);
      @(negedge clk);
      chk_b("to_done_pulse", rd_line_done, 1'b0);
      chk_b("to_sticky", timeout_err, 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
